// File: rtl/gate_tester_pkg.sv
// Shared definitions for the gate tester host link: receiver FSM encoding,
// host command codes and the baud divider helper.
package gate_tester_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Host command codes decoded by the sequencer from received bytes
    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;

    // Clocks per oversample tick, integer floor
    function automatic int baud_div(input int clk_freq_hz, input int baud, input int oversample);
        return clk_freq_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clk tick enable every DIV clocks.
// A synchronous restart realigns the tick phase; shared with the transmitter.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..DIV-1, wrapping; restart forces the phase back to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            // NOTE: non-blocking assignment for all clocked state so every flop
            // samples pre-edge values, independent of statement order.
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Tick is held off during the restart cycle so the first tick is a full DIV later
    assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchroniser, oversampled mid-bit sampling FSM,
// one-cycle rx_done / rx_frame_err strobes and a held rx_data register.
module uart_rx_byte
    import gate_tester_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115_200,
    parameter int OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

    if (DIV < 1) begin : g_div_check
        $error("uart_rx_byte: CLK_FREQ_HZ/(BAUD*OVERSAMPLE) must be >= 1");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_os_check
        $error("uart_rx_byte: OVERSAMPLE must be even and >= 4");
    end

    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    rx_state_e       state;
    logic [TW-1:0]   tick_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            tick;
    logic            start_edge;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Only a genuine 1->0 transition arms the receiver; a stuck-low line cannot
    assign start_edge = (state == ST_IDLE) && rx_prev && !rx_sync;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (start_edge),
        .tick    (tick)
    );

    // Frame FSM: mid-bit sampling of start, 8 data bits LSB first, and stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            rx_data      <= '0;
            rx_done      <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            rx_done      <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state    <= ST_START;
                        rx_busy  <= 1'b1;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            if (!rx_sync) begin
                                state <= ST_DATA;
                            end else begin
                                // Glitch shorter than half a bit: drop it silently
                                state   <= ST_IDLE;
                                rx_busy <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt  <= '0;
                            shift_reg <= {rx_sync, shift_reg[7:1]};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= ST_STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            if (rx_sync) begin
                                rx_data <= shift_reg;
                                rx_done <= 1'b1;
                            end else begin
                                rx_frame_err <= 1'b1;
                            end
                            // Leave at stop mid-bit: half a bit of margin for the next start
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed frames plus randomized
// traffic, compared against a frame-level model of the 8N1 protocol.
module tb_uart_rx_byte;

    localparam int CLK_FREQ_HZ = 1_600_000;
    localparam int BAUD        = 10_000;
    localparam int OVERSAMPLE  = 16;
    localparam int BIT_CLK     = CLK_FREQ_HZ / BAUD;   // 160

    typedef struct {
        int         kind;    // 1 = good byte, 2 = framing error
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_frame_err;
    logic       rx_busy;

    int   n_checks;
    int   n_fail;
    int   cyc;
    int   fall_cyc;
    logic [7:0] last_good;
    logic [7:0] prev_data;
    ev_t  got_q[$];
    ev_t  exp_q[$];

    uart_rx_byte #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD),
        .OVERSAMPLE  (OVERSAMPLE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Record every strobe seen by the sequencer; also watch rx_data stability
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_done)      got_q.push_back('{kind: 1, data: rx_data, cyc: cyc});
            if (rx_frame_err) got_q.push_back('{kind: 2, data: rx_data, cyc: cyc});
            if (rx_data !== prev_data && !rx_done)
                check("data_stable", rx_data, prev_data);
        end
        prev_data = rx_data;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame; bit_clk sets the line rate. Model: stop=1 yields the
    // byte, stop=0 yields a framing error with the last good byte still shown.
    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int bit_clk);
        if (stop_val) begin
            exp_q.push_back('{kind: 1, data: d, cyc: 0});
            last_good = d;
        end else begin
            exp_q.push_back('{kind: 2, data: last_good, cyc: 0});
        end
        rx = 1'b0;
        fall_cyc = cyc;
        wait_clks(bit_clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(bit_clk);
        end
        rx = stop_val;
        wait_clks(bit_clk);
    endtask

    task automatic compare_events(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_kind"}, got_q[i].kind, exp_q[i].kind);
            check({tag, "_data"}, got_q[i].data, exp_q[i].data);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, rx_data, 8'h00);
        check({tag, "_done"}, rx_done, 1'b0);
        check({tag, "_ferr"}, rx_frame_err, 1'b0);
        check({tag, "_busy"}, rx_busy, 1'b0);
    endtask

    initial begin
        logic [7:0] b77;
        int         t0;
        int         busy_seen;
        int         busy_low_at;

        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        last_good = 8'h00;
        prev_data = 8'h00;
        rst_n     = 1'b0;
        rx        = 1'b1;

        wait_clks(5);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_clks(50);

        // 1. Single good frame with latency check
        fork
            send_frame(8'hA5, 1'b1, BIT_CLK);
            begin
                wait_clks(10);
                check("t1_busy_mid", rx_busy, 1'b1);
            end
        join
        wait_clks(100);
        if (got_q.size() > 0) begin
            t0 = got_q[0].cyc - fall_cyc;
            check("t1_latency_in_window", (t0 >= 1517 && t0 <= 1523) ? 1 : 0, 1);
        end
        check("t1_rx_data", rx_data, 8'hA5);
        compare_events("t1");

        // 4. Framing error, stuck-low line, then recovery
        send_frame(8'h3C, 1'b0, BIT_CLK);
        wait_clks(2000);
        check("t4_busy_low_hold", rx_busy, 1'b0);
        check("t4_rx_data_held", rx_data, 8'hA5);
        compare_events("t4a");
        rx = 1'b1;
        wait_clks(200);
        check("t4_no_event_on_rise", got_q.size(), 0);
        send_frame(8'h5A, 1'b1, BIT_CLK);
        rx = 1'b1;
        wait_clks(100);
        compare_events("t4b");

        // 2. Back-to-back frames with one stop bit
        send_frame(8'h00, 1'b1, BIT_CLK);
        send_frame(8'hFF, 1'b1, BIT_CLK);
        wait_clks(100);
        check("t2_rx_data", rx_data, 8'hFF);
        compare_events("t2");

        // 3. 30-clk glitch is a false start
        busy_seen   = 0;
        busy_low_at = -1;
        rx = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 200; i++) begin
            if (i == 30) rx = 1'b1;
            @(negedge clk);
            if (rx_busy) busy_seen = 1;
            if (busy_seen && !rx_busy && busy_low_at < 0) busy_low_at = cyc - t0;
        end
        check("t3_busy_seen", busy_seen, 1);
        check("t3_busy_release_window", (busy_low_at >= 75 && busy_low_at <= 90) ? 1 : 0, 1);
        compare_events("t3");

        // 5. Reset during data bit 4 of 0x77
        b77 = 8'h77;
        rx  = 1'b0;
        wait_clks(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = b77[i];
            wait_clks(BIT_CLK);
        end
        rx = b77[4];
        wait_clks(BIT_CLK / 2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        rx = 1'b1;
        last_good = 8'h00;
        prev_data = 8'h00;
        wait_clks(20);
        rst_n = 1'b1;
        wait_clks(BIT_CLK * 12);
        compare_events("t5a");
        send_frame(8'h81, 1'b1, BIT_CLK);
        wait_clks(100);
        check("t5_rx_data", rx_data, 8'h81);
        compare_events("t5b");

        // 6. +/-3% baud mismatch
        send_frame(8'hC3, 1'b1, 155);
        rx = 1'b1;
        wait_clks(100);
        send_frame(8'hC3, 1'b1, 165);
        rx = 1'b1;
        wait_clks(100);
        compare_events("t6");

        // Randomized traffic: random bytes, stop bits, small rate offsets, gaps
        for (int f = 0; f < 16; f++) begin
            logic [7:0] d;
            logic       stop_val;
            int         bclk;
            int         gap;
            d        = 8'($urandom);
            stop_val = ($urandom_range(0, 5) != 0);
            bclk     = $urandom_range(156, 164);
            send_frame(d, stop_val, bclk);
            gap = stop_val ? $urandom_range(0, 200) : $urandom_range(20, 200);
            rx  = 1'b1;
            wait_clks(gap);
        end
        wait_clks(200);
        check("rand_rx_data", rx_data, last_good);
        compare_events("rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #(64'd10 * 64'd90_000);
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
